// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StHeld
  } state_e;

  // Classification of one full scan (MULTI is treated as NONE by the FSM)
  typedef enum logic [1:0] {
    ResNone,
    ResSingle,
    ResMulti
  } scan_res_e;

  // Active-low one-hot column drive patterns
  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  // Hex code of a key: row*4 + column
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

  // Column index to active-low drive pattern
  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    logic [3:0] drive;
    case (idx)
      2'd0:    drive = COL_0;
      2'd1:    drive = COL_1;
      2'd2:    drive = COL_2;
      default: drive = COL_3;
    endcase
    return drive;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Board-side keypad pins plus the decoded key outputs.
// master: the scanner; slave: the board model / key consumer.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [3:0] key;
  logic       key_valid;
  logic       key_strobe;

  modport master (
    input  rows,
    output columns,
    output key,
    output key_valid,
    output key_strobe
  );

  modport slave (
    output rows,
    input  columns,
    input  key,
    input  key_valid,
    input  key_strobe
  );
endinterface

// File: rtl/keypad_scan_timer.sv
// Column dwell prescaler and 4-column ring. sample_en marks the last cycle of
// each dwell; end_of_scan marks the last cycle of column 3's dwell.
module keypad_scan_timer #(
  parameter int unsigned SCAN_DIV = 1024
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic [1:0] col_idx_o,
  output logic       sample_en_o,
  output logic       end_of_scan_o
);

  localparam int unsigned      DivW    = $clog2(SCAN_DIV);
  localparam logic [DivW-1:0]  DivLast = DivW'(SCAN_DIV - 1);

  logic [DivW-1:0] div_q, div_d;
  logic [1:0]      col_q, col_d;
  logic            last_cycle;

  // Prescaler wraps at the end of each dwell and steps the column ring
  always_comb begin
    last_cycle = (div_q == DivLast);
    div_d      = last_cycle ? '0 : div_q + 1'b1;
    col_d      = last_cycle ? col_q + 2'd1 : col_q;
  end

  // Prescaler and ring registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      col_q <= '0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
    end
  end

  assign col_idx_o     = col_q;
  assign sample_en_o   = last_cycle;
  assign end_of_scan_o = last_cycle && (col_q == 2'd3);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes columns, synchronizes and samples rows,
// classifies each full scan and debounces press/release over whole scans.
// Optional feature macro: KEYPAD_AUTOREPEAT_EN (auto-repeat strobes while held).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1024,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned REPEAT_SCANS   = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  keypad_scanner_if.master  kp
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CntW-1:0] DebLim = CntW'(DEBOUNCE_SCANS);

  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 4");
  end
  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 255) begin : g_bad_debounce
    $error("DEBOUNCE_SCANS must be in 1..255");
  end
  if (REPEAT_SCANS < 1) begin : g_bad_repeat
    $error("REPEAT_SCANS must be at least 1");
  end

  logic [1:0] col_idx;
  logic       sample_en;
  logic       end_of_scan;

  keypad_scan_timer #(
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clock         (clock),
    .reset_n       (reset_n),
    .col_idx_o     (col_idx),
    .sample_en_o   (sample_en),
    .end_of_scan_o (end_of_scan)
  );

  assign kp.columns = col_drive(col_idx);

  // Two-flop row synchronizer; idles high like the pulled-up pins
  logic [3:0] rows_meta_q, rows_sync_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rows_meta_q <= 4'hF;
      rows_sync_q <= 4'hF;
    end else begin
      rows_meta_q <= kp.rows;
      rows_sync_q <= rows_meta_q;
    end
  end

  scan_res_e  acc_res_q, merged_res;
  logic [3:0] acc_code_q, merged_code;
  scan_res_e  scan_res_q;
  logic [3:0] scan_code_q;
  logic       scan_done_q;
  logic [3:0] pressed;
  logic [2:0] hits;
  logic [1:0] row_idx;

  // Fold the current column's sample into the running scan result
  always_comb begin
    pressed     = ~rows_sync_q;
    hits        = '0;
    row_idx     = '0;
    merged_res  = acc_res_q;
    merged_code = acc_code_q;
    for (int r = 0; r < 4; r++) begin
      if (pressed[r]) begin
        hits    = hits + 3'd1;
        row_idx = 2'(r);
      end
    end
    if (hits > 3'd1) begin
      merged_res = ResMulti;
    end else if (hits == 3'd1) begin
      if (acc_res_q == ResNone) begin
        merged_res  = ResSingle;
        merged_code = key_code(row_idx, col_idx);
      end else begin
        merged_res = ResMulti;
      end
    end
  end

  // Accumulator, plus a registered per-scan result with a one-cycle done pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_res_q   <= ResNone;
      acc_code_q  <= '0;
      scan_res_q  <= ResNone;
      scan_code_q <= '0;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (sample_en) begin
        if (end_of_scan) begin
          scan_res_q  <= merged_res;
          scan_code_q <= merged_code;
          scan_done_q <= 1'b1;
          acc_res_q   <= ResNone;
          acc_code_q  <= '0;
        end else begin
          acc_res_q  <= merged_res;
          acc_code_q <= merged_code;
        end
      end
    end
  end

  state_e          state_q, state_d;
  logic [3:0]      cand_q, cand_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CntW-1:0] rel_q, rel_d, rel_inc;
  logic [3:0]      key_q, key_d;
  logic            valid_q, valid_d;
  logic            strobe_q, strobe_d;
  logic            is_single;
  logic            held_match;
  logic            accept;
  logic            rep_fire;

  assign is_single  = (scan_res_q == ResSingle);
  assign held_match = is_single && (scan_code_q == key_q);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned     RepW   = $clog2(REPEAT_SCANS + 1);
  localparam logic [RepW-1:0] RepLim = RepW'(REPEAT_SCANS);

  logic [RepW-1:0] rep_q, rep_d, rep_inc;

  // Count consecutive matching scans in HELD; anything else clears the count
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    rep_inc  = rep_q + 1'b1;
    if (scan_done_q) begin
      if (state_q == StHeld && held_match) begin
        if (rep_inc >= RepLim) begin
          rep_fire = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_inc;
        end
      end else begin
        rep_d = '0;
      end
    end
  end

  // Repeat counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rep_q <= '0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounce FSM next-state; acts only on the scan-done pulse
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    rel_d    = rel_q;
    key_d    = key_q;
    valid_d  = valid_q;
    strobe_d = 1'b0;
    accept   = 1'b0;
    cnt_inc  = (cnt_q >= DebLim) ? cnt_q : cnt_q + 1'b1;
    rel_inc  = (rel_q >= DebLim) ? rel_q : rel_q + 1'b1;
    if (scan_done_q) begin
      case (state_q)
        StIdle: begin
          cnt_d = '0;
          if (is_single) begin
            if (DEBOUNCE_SCANS == 1) begin
              accept = 1'b1;
            end else begin
              cand_d  = scan_code_q;
              cnt_d   = CntW'(1);
              state_d = StDebounce;
            end
          end
        end
        StDebounce: begin
          if (is_single && scan_code_q == cand_q) begin
            if (cnt_inc >= DebLim) begin
              accept = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          // A different single key counts toward release, not as a new press
          if (held_match) begin
            rel_d    = '0;
            strobe_d = rep_fire;
          end else if (rel_inc >= DebLim) begin
            rel_d   = '0;
            valid_d = 1'b0;
            state_d = StIdle;
          end else begin
            rel_d = rel_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          rel_d   = '0;
        end
      endcase
    end
    if (accept) begin
      key_d    = scan_code_q;
      valid_d  = 1'b1;
      strobe_d = 1'b1;
      state_d  = StHeld;
      cnt_d    = '0;
      rel_d    = '0;
    end
  end

  // FSM and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cand_q   <= '0;
      cnt_q    <= '0;
      rel_q    <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      rel_q    <= rel_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
      strobe_q <= strobe_d;
    end
  end

  assign kp.key        = key_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=8
// (one scan = 16 cycles). A keypad model pulls rows low for pressed keys on
// the driven column.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mask = '0;
  int unsigned cyc;
  int          total = 0;
  int          bad = 0;
  int          strobe_seen = 0;
  int          proto_err = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (8)
  ) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .kp      (kp)
  );

  always #5 clk = ~clk;

  // Keypad model: pressed key (r,c) pulls row r low while column c is driven
  always_comb begin
    kp.rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!kp.columns[c] && mask[r*4+c]) kp.rows[r] = 1'b0;
      end
    end
  end

  // Edge count since the last reset release
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (kp.key_strobe) strobe_seen++;
    if (kp.key_strobe && !kp.key_valid) proto_err++;
  end

  typedef struct {
    logic [15:0] mask;
    int          scans;
    int          exp_strobes;
    logic        exp_valid;
    logic [3:0]  exp_key;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait for the negedge after edge n, then settle 1 time unit
  task automatic wait_until(input int unsigned n);
    int guard = 0;
    while (cyc < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      total++;
      bad++;
      $display("FAIL wait_until: reached cycle %0d, expected %0d", cyc, n);
    end
    #1;
  endtask

  task automatic do_reset(input int hold);
    reset_n = 1'b0;
    repeat (hold) @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " columns"}, 32'(kp.columns), 32'h0000_000E);
    check({tag, " key"}, 32'(kp.key), 32'h0);
    check({tag, " key_valid"}, 32'(kp.key_valid), 32'h0);
    check({tag, " key_strobe"}, 32'(kp.key_strobe), 32'h0);
  endtask

  initial begin
    int unsigned base;
    int          s0;

    vecs[0]  = '{16'h0040,  1, 0, 1'b0, 4'h0};  // code 6 for one scan only
    vecs[1]  = '{16'h0000,  3, 0, 1'b0, 4'h0};
    vecs[2]  = '{16'h0040,  1, 0, 1'b0, 4'h0};  // alternate 6 / 7
    vecs[3]  = '{16'h0080,  1, 0, 1'b0, 4'h0};
    vecs[4]  = '{16'h0040,  1, 0, 1'b0, 4'h0};
    vecs[5]  = '{16'h0080,  1, 0, 1'b0, 4'h0};
    vecs[6]  = '{16'h0040,  1, 0, 1'b0, 4'h0};
    vecs[7]  = '{16'h0000,  2, 0, 1'b0, 4'h0};
    vecs[8]  = '{16'h0021, 10, 0, 1'b0, 4'h0};  // codes 0 and 5 together
    vecs[9]  = '{16'h0001,  3, 1, 1'b1, 4'h0};  // release 5, code 0 accepted
    vecs[10] = '{16'h0001,  4, 0, 1'b1, 4'h0};
    vecs[11] = '{16'h1000,  3, 0, 1'b0, 4'h0};  // different key acts as release
    vecs[12] = '{16'h1000,  3, 1, 1'b1, 4'hC};  // then a fresh press of C
    vecs[13] = '{16'h1000,  2, 0, 1'b1, 4'hC};

    // Reset held while rows toggle
    for (int i = 0; i < 4; i++) begin
      mask = 16'($urandom);
      @(negedge clk);
      #1;
      check_reset_outputs("in reset");
    end

    // Clean press of code 9 (row 2, column 1), present from scan 0
    mask = 16'h0200;
    #1;
    reset_n = 1'b1;
    wait_until(3);
    check("column before first step", 32'(kp.columns), 32'h0000_000E);
    wait_until(4);
    check("first column step", 32'(kp.columns), 32'h0000_000D);
    wait_until(48);
    check("strobe before 49", 32'(kp.key_strobe), 32'h0);
    check("valid before 49", 32'(kp.key_valid), 32'h0);
    wait_until(49);
    check("strobe at 49", 32'(kp.key_strobe), 32'h1);
    check("valid at 49", 32'(kp.key_valid), 32'h1);
    check("key at 49", 32'(kp.key), 32'h9);
    wait_until(50);
    check("strobe width", 32'(kp.key_strobe), 32'h0);
    check("valid held", 32'(kp.key_valid), 32'h1);
    wait_until(81);
    mask = '0;
    wait_until(128);
    check("valid before release", 32'(kp.key_valid), 32'h1);
    wait_until(129);
    check("valid after release", 32'(kp.key_valid), 32'h0);
    check("key kept after release", 32'(kp.key), 32'h9);

    // Table of scan-aligned stimulus, state carried between rows
    mask = '0;
    do_reset(3);
    wait_until(1);
    base = 1;
    s0 = strobe_seen;
    for (int i = 0; i < 14; i++) begin
      mask = vecs[i].mask;
      base += 16 * vecs[i].scans;
      wait_until(base);
      check($sformatf("vec%0d strobes", i), 32'(strobe_seen - s0), 32'(vecs[i].exp_strobes));
      check($sformatf("vec%0d key_valid", i), 32'(kp.key_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d key", i), 32'(kp.key), 32'(vecs[i].exp_key));
      s0 = strobe_seen;
    end

    // Short reset pulse between edges while holding C
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid-hold reset");
    #1;
    reset_n = 1'b1;
    wait_until(48);
    check("reaccept strobe early", 32'(kp.key_strobe), 32'h0);
    check("reaccept valid early", 32'(kp.key_valid), 32'h0);
    wait_until(49);
    check("reaccept strobe", 32'(kp.key_strobe), 32'h1);
    check("reaccept valid", 32'(kp.key_valid), 32'h1);
    check("reaccept key", 32'(kp.key), 32'hC);

    // Hold code 3 for 30 scans
    mask = 16'h0008;
    do_reset(2);
    s0 = strobe_seen;
    wait_until(49);
    check("hold3 accept strobe", 32'(kp.key_strobe), 32'h1);
    check("hold3 accept key", 32'(kp.key), 32'h3);
    wait_until(176);
    check("hold3 before repeat", 32'(kp.key_strobe), 32'h0);
    wait_until(177);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold3 first repeat", 32'(kp.key_strobe), 32'h1);
`else
    check("hold3 no repeat", 32'(kp.key_strobe), 32'h0);
`endif
    wait_until(481);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("hold3 strobe count", 32'(strobe_seen - s0), 32'h4);
`else
    check("hold3 strobe count", 32'(strobe_seen - s0), 32'h1);
`endif
    check("hold3 valid", 32'(kp.key_valid), 32'h1);
    check("hold3 key", 32'(kp.key), 32'h3);

    check("strobe without valid", 32'(proto_err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
